// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit.
//   md_op_e    : operation encodings driven on the 'op' port
//   md_state_e : sequencer states (IDLE -> CALC -> FIX -> IDLE)
//   ITER_COUNT : number of shift-add / restoring-divide iterations
//   negate32/negate64 : two's complement negation through an incrementer,
//                       kept away from the per-iteration adder
// ---------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_e;

    localparam int unsigned ITER_COUNT = 32;
    localparam int unsigned CNT_W      = 5;

    // Bit 0 of the encoding clears for the signed flavours.
    function automatic logic is_signed_op(input md_op_e op);
        return ~op[0];
    endfunction

    function automatic logic is_div_op(input md_op_e op);
        return op[1];
    endfunction

    function automatic logic [31:0] negate32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [63:0] negate64(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

endpackage

// File: rtl/muldiv_unit_adder.sv
// ---------------------------------------------------------------------------
// Adder32
// 32-bit ripple-carry adder shared by every multiply and divide iteration.
//   a, b  : in  32-bit addends
//   sum   : out 32-bit sum
//   carry : out carry out of bit 31
// ---------------------------------------------------------------------------
module Adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        carry
);

    // Bit-serial carry chain, one full adder per bit.
    always_comb begin
        logic [32:0] chain;
        chain = '0;
        sum   = '0;
        for (int i = 0; i < 32; i++) begin
            sum[i]       = a[i] ^ b[i] ^ chain[i];
            chain[i + 1] = (a[i] & b[i]) | (chain[i] & (a[i] ^ b[i]));
        end
        carry = chain[32];
    end

endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// Fixed 33-cycle latency: 32 iterations through one shared Adder32 followed
// by a sign-fix/writeback cycle.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start, op    : launch an operation (sampled only while idle)
//   a, b         : rs / rt operands
//   hi_we, lo_we, wdata : MTHI / MTLO writes (idle only, dropped on start)
//   busy  : out, operation in progress
//   done  : out, one-cycle pulse when HI/LO take a result
//   hi, lo: out, architectural HI/LO
// ---------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e         state;
    md_state_e         next_state;
    md_op_e            op_in;
    md_op_e            op_q;

    logic              load_en;
    logic              calc_en;
    logic              fix_en;
    logic              mt_en;

    logic              sign_a;
    logic              sign_b;
    logic              div_zero;
    logic [31:0]       a_orig;
    logic [31:0]       operand;
    logic [31:0]       neg_div;
    logic [31:0]       work_hi;
    logic [31:0]       work_lo;
    logic [CNT_W-1:0]  count;

    logic              in_sign_a;
    logic              in_sign_b;
    logic [31:0]       mag_a;
    logic [31:0]       mag_b;
    logic [31:0]       neg_mag_b;

    logic [32:0]       rem_shift;
    logic [31:0]       add_a;
    logic [31:0]       add_b;
    logic [31:0]       add_sum;
    logic              add_carry;
    logic              take;
    logic [31:0]       next_hi;
    logic [31:0]       next_lo;

    logic [63:0]       product;
    logic [31:0]       fix_hi;
    logic [31:0]       fix_lo;

    assign op_in = md_op_e'(op);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = CALC;
            CALC: if (count == CNT_W'(ITER_COUNT - 1)) next_state = FIX;
            FIX:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Control outputs; an MTHI/MTLO coinciding with start is dropped.
    always_comb begin
        busy    = (state != IDLE);
        load_en = (state == IDLE) && start;
        mt_en   = (state == IDLE) && !start;
        calc_en = (state == CALC);
        fix_en  = (state == FIX);
    end

    // Operand magnitudes at launch. The negated divisor magnitude is
    // simply b itself when b was negative, so only one negation is needed.
    always_comb begin
        in_sign_a = is_signed_op(op_in) & a[31];
        in_sign_b = is_signed_op(op_in) & b[31];
        mag_a     = in_sign_a ? negate32(a) : a;
        mag_b     = in_sign_b ? negate32(b) : b;
        neg_mag_b = in_sign_b ? b : negate32(b);
    end

    // Adder operand steering: multiply adds the multiplicand into the
    // accumulator, divide adds the negated divisor to the shifted remainder.
    always_comb begin
        rem_shift = {work_hi, work_lo[31]};
        if (is_div_op(op_q)) begin
            add_a = rem_shift[31:0];
            add_b = neg_div;
        end else begin
            add_a = work_hi;
            add_b = work_lo[0] ? operand : 32'd0;
        end
    end

    Adder32 u_adder (
        .a     (add_a),
        .b     (add_b),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // One iteration. A set rem_shift[32] or an adder carry both mean the
    // shifted remainder is at least the divisor, so the subtraction stands.
    always_comb begin
        take = 1'b0;
        if (is_div_op(op_q)) begin
            take    = rem_shift[32] | add_carry;
            next_hi = take ? add_sum : rem_shift[31:0];
            next_lo = {work_lo[30:0], take};
        end else begin
            next_hi = {add_carry, add_sum[31:1]};
            next_lo = {add_sum[0], work_lo[31:1]};
        end
    end

    // Sign correction and divide-by-zero override for the writeback cycle.
    always_comb begin
        product = {work_hi, work_lo};
        if (!is_div_op(op_q)) begin
            if (sign_a ^ sign_b) product = negate64(product);
            fix_hi = product[63:32];
            fix_lo = product[31:0];
        end else if (div_zero) begin
            fix_hi = a_orig;
            fix_lo = 32'hFFFF_FFFF;
        end else begin
            fix_hi = sign_a ? negate32(work_hi) : work_hi;
            fix_lo = (sign_a ^ sign_b) ? negate32(work_lo) : work_lo;
        end
    end

    // Working registers: loaded at launch, stepped once per CALC cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q     <= MD_MULT;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            a_orig   <= '0;
            operand  <= '0;
            neg_div  <= '0;
            work_hi  <= '0;
            work_lo  <= '0;
            count    <= '0;
        end else if (load_en) begin
            op_q     <= op_in;
            sign_a   <= in_sign_a;
            sign_b   <= in_sign_b;
            div_zero <= (b == 32'd0);
            a_orig   <= a;
            neg_div  <= neg_mag_b;
            work_hi  <= '0;
            count    <= '0;
            if (is_div_op(op_in)) begin
                work_lo <= mag_a;
                operand <= mag_b;
            end else begin
                work_lo <= mag_b;
                operand <= mag_a;
            end
        end else if (calc_en) begin
            work_hi <= next_hi;
            work_lo <= next_lo;
            count   <= count + CNT_W'(1);
        end
    end

    // Architectural HI/LO plus the done pulse; old values stay visible
    // until the FIX cycle overwrites them.
    always_ff @(posedge clock) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= fix_en;
            if (fix_en) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end else if (mt_en) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Directed vectors with literal expected HI/LO, plus a cycle-level
// behavioural model of the unit that is compared against every cycle.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    muldiv_unit dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clock = ~clock;

    // Single place where comparisons are counted and failures reported.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [1:0] o,
                                 input logic [31:0] x, input logic [31:0] y,
                                 input logic hwe, input logic lwe,
                                 input logic [31:0] wd);
        start = st;
        op    = o;
        a     = x;
        b     = y;
        hi_we = hwe;
        lo_we = lwe;
        wdata = wd;
    endtask

    // Architectural result straight from the instruction semantics.
    function automatic void modelResult(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y,
                                        output logic [31:0] rh, output logic [31:0] rl);
        int          sx;
        int          sy;
        longint      sp;
        logic [63:0] up;
        sx = x;
        sy = y;
        case (o)
            2'b00: begin
                sp = longint'(sx) * longint'(sy);
                up = sp;
                rh = up[63:32];
                rl = up[31:0];
            end
            2'b01: begin
                up = {32'd0, x} * {32'd0, y};
                rh = up[63:32];
                rl = up[31:0];
            end
            2'b10: begin
                if (y == 32'd0) begin
                    rh = x;
                    rl = 32'hFFFF_FFFF;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    rh = 32'd0;
                    rl = 32'h8000_0000;
                end else begin
                    rl = sx / sy;
                    rh = sx % sy;
                end
            end
            default: begin
                if (y == 32'd0) begin
                    rh = x;
                    rl = 32'hFFFF_FFFF;
                end else begin
                    rl = x / y;
                    rh = x % y;
                end
            end
        endcase
    endfunction

    // Cycle-level model: 33 edges from acceptance to writeback.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    int          remaining = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_busy    = 1'b0;
            m_done    = 1'b0;
            m_hi      = '0;
            m_lo      = '0;
            remaining = 0;
        end else if (m_busy) begin
            m_done = 1'b0;
            remaining--;
            if (remaining == 0) begin
                m_hi   = pend_hi;
                m_lo   = pend_lo;
                m_done = 1'b1;
                m_busy = 1'b0;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                modelResult(op, a, b, pend_hi, pend_lo);
                m_busy    = 1'b1;
                remaining = 33;
            end else begin
                if (hi_we) m_hi = wdata;
                if (lo_we) m_lo = wdata;
            end
        end
    end

    // Compare every cycle once reset has been applied.
    always @(negedge clock) begin
        if (check_en) begin
            checkOutput("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
            checkOutput("cyc_done", {31'd0, done}, {31'd0, m_done});
            checkOutput("cyc_hi", hi, m_hi);
            checkOutput("cyc_lo", lo, m_lo);
        end
    end

    // Launch one operation and pin latency, busy length and the literal result.
    task automatic runOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input string nm);
        int cycles;
        int busy_cycles;
        bit seen;
        applyStimulus(1'b1, o, x, y, 1'b0, 1'b0, 32'd0);
        @(posedge clock); #1;
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        busy_cycles = busy ? 1 : 0;
        cycles      = 0;
        seen        = 1'b0;
        while (!seen && cycles < 40) begin
            @(posedge clock); #1;
            cycles++;
            if (done) seen = 1'b1;
            else if (busy) busy_cycles++;
        end
        checkOutput({nm, "_latency"}, 32'(cycles), 32'd33);
        checkOutput({nm, "_busylen"}, 32'(busy_cycles), 32'd33);
        checkOutput({nm, "_hi"}, hi, eh);
        checkOutput({nm, "_lo"}, lo, el);
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] eh;
        logic [31:0] el;
        string       nm;
    } vec_t;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
        vecs[1]  = '{MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_m3x7"};
        vecs[2]  = '{MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        "divu_100_7"};
        vecs[3]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2"};
        vecs[4]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, "div_ovf"};
        vecs[5]  = '{MD_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, "divu_by0"};
        vecs[6]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_by0"};
        vecs[7]  = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, "div_7_m2"};
        vecs[8]  = '{MD_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         "div_m7_m2"};
        vecs[9]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         "mult_min2"};
        vecs[10] = '{MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         "multu_2p32"};
        vecs[11] = '{MD_MULT,  32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, "mult_7_m1"};
        vecs[12] = '{MD_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, "divu_max_1"};
        vecs[13] = '{MD_DIVU,  32'd3,         32'd10,        32'd3,         32'd0,         "divu_small"};
    end

    initial begin
        int done_pulses;
        reset = 1'b1;
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset    = 1'b0;
        check_en = 1'b1;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);

        // Back-to-back: each op starts in the cycle its predecessor's done is high.
        foreach (vecs[i]) runOp(vecs[i].o, vecs[i].x, vecs[i].y, vecs[i].eh, vecs[i].el, vecs[i].nm);

        // MTHI / MTLO while idle.
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 32'h0000_1234);
        @(posedge clock); #1;
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'h0000_5678);
        @(posedge clock); #1;
        checkOutput("mthi_hi", hi, 32'h0000_1234);
        checkOutput("mtlo_lo", lo, 32'h0000_5678);

        // Start together with MTLO: the write is dropped, the op proceeds.
        applyStimulus(1'b1, MD_MULTU, 32'd2, 32'd3, 1'b0, 1'b1, 32'hDEAD_BEEF);
        @(posedge clock); #1;
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("start_wr_lo", lo, 32'h0000_5678);
        checkOutput("start_busy", {31'd0, busy}, 32'd1);

        // Start pulse and MTHI at iteration 10 are both ignored.
        repeat (10) @(posedge clock);
        applyStimulus(1'b1, MD_DIV, 32'd9, 32'd4, 1'b1, 1'b0, 32'hCAFE_F00D);
        @(posedge clock); #1;
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("midrun_hi", hi, 32'h0000_1234);
        checkOutput("midrun_lo", lo, 32'h0000_5678);

        // Reset at iteration 20 discards the operation.
        repeat (9) @(posedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_hi", hi, 32'd0);
        checkOutput("rst_lo", lo, 32'd0);
        done_pulses = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) done_pulses++;
        end
        checkOutput("rst_no_done", 32'(done_pulses), 32'd0);

        // Unit recovers after the aborted operation.
        runOp(MD_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, "after_reset");

        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
